// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay renderer: colours, per-element
// origin/visibility record, hit-test modes and the element-count ceiling.
package overlay_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_RED   = 24'hff0000;
    localparam rgb_t RGB_BLACK = 24'h000000;

    // 8 boxes + 4 windows
    localparam int MAX_ELEMS = 12;

    // Stored coordinate width; wide enough for any supported X_W/Y_W.
    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] x;
        logic [CFG_W-1:0] y;
        logic             en;
    } elem_cfg_t;

    typedef enum logic {
        MODE_OUTLINE = 1'b0,
        MODE_FILL    = 1'b1
    } hit_mode_e;

    function automatic elem_cfg_t make_cfg(input int x, input int y, input logic en);
        elem_cfg_t c;
        c.x  = CFG_W'(x);
        c.y  = CFG_W'(y);
        c.en = en;
        return c;
    endfunction

endpackage

// File: rtl/overlay_renderer_if.sv
// Pixel, configuration, ROM and output signals of the overlay renderer.
// slave = renderer view, master = source/sink/ROM view.
interface overlay_renderer_if
    import overlay_pkg::*;
#(
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int NUM_WIN = 2,
    parameter int ADDR_W  = 10
);
    logic               pix_valid;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    rgb_t               pix_rgb;
    logic               frame_start;
    logic               cfg_we;
    logic [3:0]         cfg_sel;
    logic [X_W-1:0]     cfg_x;
    logic [Y_W-1:0]     cfg_y;
    logic               cfg_en;
    logic [NUM_WIN-1:0] rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic               out_valid;
    rgb_t               out_rgb;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start,
        input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
        output rom_en, rom_addr,
        input  rom_data,
        output out_valid, out_rgb
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start,
        output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en,
        input  rom_en, rom_addr,
        output rom_data,
        input  out_valid, out_rgb
    );
endinterface

// File: rtl/overlay_hit_test.sv
// Single-element rectangle test: 1 px perimeter (outline) or interior (fill),
// combinational. Fill mode also yields the pixel offset inside the rectangle.
module overlay_hit_test
    import overlay_pkg::*;
#(
    parameter hit_mode_e MODE = MODE_OUTLINE,
    parameter int        X_W  = 11,
    parameter int        Y_W  = 10,
    parameter int        W    = 100,
    parameter int        H    = 100
) (
    input  elem_cfg_t      cfg,
    input  logic [X_W-1:0] px,
    input  logic [Y_W-1:0] py,
    output logic           hit,
    output logic [X_W-1:0] dx,
    output logic [Y_W-1:0] dy
);
    localparam int CW = CFG_W + 1;

    // One spare bit so a far edge past the last coordinate never wraps to a match.
    logic [CW-1:0] x0, x1, xe;
    logic [CW-1:0] y0, y1, ye;
    logic          in_x, in_y;

    assign x0 = {1'b0, cfg.x};
    assign y0 = {1'b0, cfg.y};
    assign x1 = x0 + CW'(W);
    assign y1 = y0 + CW'(H);
    assign xe = CW'(px);
    assign ye = CW'(py);

    assign dx = X_W'(xe - x0);
    assign dy = Y_W'(ye - y0);

    always_comb begin
        hit  = 1'b0;
        in_x = (xe >= x0) && (xe <= x1);
        in_y = (ye >= y0) && (ye <= y1);
        if (MODE == MODE_OUTLINE) begin
            hit = cfg.en && ((((xe == x0) || (xe == x1)) && in_y) ||
                             (((ye == y0) || (ye == y1)) && in_x));
        end else begin
            hit = cfg.en && (xe >= x0) && (xe < x1) && (ye >= y0) && (ye < y1);
        end
    end
endmodule

// File: rtl/overlay_renderer.sv
// Draws outline boxes and ROM-backed greyscale windows over a pixel stream.
// Latency 2 cycles, 1 pixel/cycle, no backpressure; config commits at frame_start.
module overlay_renderer
    import overlay_pkg::*;
#(
    parameter int   X_W       = 11,
    parameter int   Y_W       = 10,
    parameter int   NUM_BOXES = 3,
    parameter int   BOX_W     = 100,
    parameter int   BOX_H     = 100,
    parameter rgb_t BOX_COLOR = RGB_RED,
    parameter int   BOX_X0    = 390,
    parameter int   BOX_Y0    = 310,
    parameter int   BOX_PITCH = 200,
    parameter int   NUM_WIN   = 2,
    parameter int   WIN_SIZE  = 30,
    parameter int   WIN_X0    = 590,
    parameter int   WIN_Y0    = 530,
    parameter int   WIN_PITCH = 70,
    parameter int   ADDR_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    overlay_renderer_if.slave   bus
);
    localparam int NE = NUM_BOXES + NUM_WIN;

    function automatic elem_cfg_t rst_cfg(input int i);
        if (i < NUM_BOXES) return make_cfg(BOX_X0 + i * BOX_PITCH, BOX_Y0, 1'b1);
        return make_cfg(WIN_X0 + (i - NUM_BOXES) * WIN_PITCH, WIN_Y0, 1'b1);
    endfunction

    elem_cfg_t pend_q [NE];
    elem_cfg_t pend_d [NE];
    elem_cfg_t act_q  [NE];
    elem_cfg_t act_d  [NE];

    // Out-of-range selects match no element and are dropped.
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            pend_d[i] = pend_q[i];
            if (bus.cfg_we && (bus.cfg_sel == 4'(i))) begin
                pend_d[i] = '{x: CFG_W'(bus.cfg_x), y: CFG_W'(bus.cfg_y), en: bus.cfg_en};
            end
            act_d[i] = bus.frame_start ? pend_d[i] : act_q[i];
        end
    end

    logic           elem_hit [NE];
    logic [X_W-1:0] elem_dx  [NE];
    logic [Y_W-1:0] elem_dy  [NE];

    for (genvar g = 0; g < NE; g++) begin : g_elem
        if (g < NUM_BOXES) begin : g_box
            overlay_hit_test #(
                .MODE(MODE_OUTLINE), .X_W(X_W), .Y_W(Y_W), .W(BOX_W), .H(BOX_H)
            ) u_hit (
                .cfg(act_q[g]), .px(bus.pix_x), .py(bus.pix_y),
                .hit(elem_hit[g]), .dx(elem_dx[g]), .dy(elem_dy[g])
            );
        end else begin : g_win
            overlay_hit_test #(
                .MODE(MODE_FILL), .X_W(X_W), .Y_W(Y_W), .W(WIN_SIZE), .H(WIN_SIZE)
            ) u_hit (
                .cfg(act_q[g]), .px(bus.pix_x), .py(bus.pix_y),
                .hit(elem_hit[g]), .dx(elem_dx[g]), .dy(elem_dy[g])
            );
        end
    end

    logic               box_any, win_any;
    logic [NUM_WIN-1:0] win_oh;
    logic [ADDR_W-1:0]  win_addr;

    logic               s1_vld_q, s1_vld_d;
    logic               s1_box_q, s1_box_d;
    rgb_t               s1_rgb_q, s1_rgb_d;
    logic [NUM_WIN-1:0] rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;

    // Descending scan so the lowest-index overlapping window wins.
    always_comb begin
        box_any  = 1'b0;
        win_any  = 1'b0;
        win_oh   = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_BOXES; i++) box_any = box_any | elem_hit[i];
        for (int j = NUM_WIN - 1; j >= 0; j--) begin
            if (elem_hit[NUM_BOXES + j]) begin
                win_any  = 1'b1;
                win_oh   = NUM_WIN'(1) << j;
                win_addr = ADDR_W'(elem_dy[NUM_BOXES + j]) * ADDR_W'(WIN_SIZE)
                         + ADDR_W'(elem_dx[NUM_BOXES + j]);
            end
        end

        s1_vld_d   = bus.pix_valid;
        s1_box_d   = box_any;
        s1_rgb_d   = bus.pix_rgb;
        rom_en_d   = bus.pix_valid ? win_oh : '0;
        rom_addr_d = (bus.pix_valid && win_any) ? win_addr : rom_addr_q;
    end

    logic s2_vld_q, s2_vld_d;
    logic s2_box_q, s2_box_d;
    logic s2_win_q, s2_win_d;
    rgb_t s2_rgb_q, s2_rgb_d;
    rgb_t hold_q,   hold_d;
    rgb_t out_rgb;

    // ROM data arrives during stage 2, so the final colour mux sits after the stage-2 flops.
    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_box_d = s1_box_q;
        s2_win_d = |rom_en_q;
        s2_rgb_d = s1_rgb_q;
        out_rgb  = hold_q;
        if (s2_vld_q) begin
            if (s2_box_q)      out_rgb = BOX_COLOR;
            else if (s2_win_q) out_rgb = {3{bus.rom_data}};
            else               out_rgb = s2_rgb_q;
        end
        hold_d = out_rgb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                pend_q[i] <= rst_cfg(i);
                act_q[i]  <= rst_cfg(i);
            end
            s1_vld_q   <= 1'b0;
            s1_box_q   <= 1'b0;
            s1_rgb_q   <= RGB_BLACK;
            rom_en_q   <= '0;
            rom_addr_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_box_q   <= 1'b0;
            s2_win_q   <= 1'b0;
            s2_rgb_q   <= RGB_BLACK;
            hold_q     <= RGB_BLACK;
        end else begin
            for (int i = 0; i < NE; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
            end
            s1_vld_q   <= s1_vld_d;
            s1_box_q   <= s1_box_d;
            s1_rgb_q   <= s1_rgb_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            s2_vld_q   <= s2_vld_d;
            s2_box_q   <= s2_box_d;
            s2_win_q   <= s2_win_d;
            s2_rgb_q   <= s2_rgb_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_valid = s2_vld_q;
    assign bus.out_rgb   = out_rgb;
endmodule
